// File: rtl/proc_param.sv
// Multi-cycle register processor: mv/mvi finish in T1 (2 cycles with fetch), ALU ops in T3 (4 cycles).
// No backpressure: Run is sampled only in T0, DIN must carry the immediate during T1 of mvi.
module proc_param #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires
);

  localparam int RW = $clog2(NREG);
  localparam int IW = 3 + 2 * RW;
  localparam int SW = $clog2(DATA_W);

  if (IW > DATA_W) begin : g_iw_check
    $error("proc_param: instruction width exceeds DATA_W");
  end
  if (NREG < 2 || (1 << RW) != NREG) begin : g_nreg_check
    $error("proc_param: NREG must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL
  } op_t;

  step_t             step, step_nxt;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] r [NREG];
  logic [DATA_W-1:0] a, g, alu;
  op_t               op;
  logic [RW-1:0]     rx, ry;
  logic              ir_ld, a_ld, g_ld, r_wr;

  assign op = op_t'(ir[IW-1 -: 3]);
  assign rx = ir[2*RW-1 -: RW];
  assign ry = ir[RW-1:0];

  // Rx is never written before T3, so X = Y reads the old value in T1 and T2.
  always_comb begin
    step_nxt = step;
    Done     = 1'b0;
    BusWires = '0;
    ir_ld    = 1'b0;
    a_ld     = 1'b0;
    g_ld     = 1'b0;
    r_wr     = 1'b0;
    case (step)
      T0: begin
        if (Run) begin
          ir_ld    = 1'b1;
          step_nxt = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            BusWires = r[ry];
            r_wr     = 1'b1;
            Done     = 1'b1;
            step_nxt = T0;
          end
          OP_MVI: begin
            BusWires = DIN;
            r_wr     = 1'b1;
            Done     = 1'b1;
            step_nxt = T0;
          end
          default: begin
            BusWires = r[rx];
            a_ld     = 1'b1;
            step_nxt = T2;
          end
        endcase
      end
      T2: begin
        BusWires = r[ry];
        g_ld     = 1'b1;
        step_nxt = T3;
      end
      T3: begin
        BusWires = g;
        r_wr     = 1'b1;
        Done     = 1'b1;
        step_nxt = T0;
      end
      default: step_nxt = T0;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = a + BusWires;
      OP_SUB:  alu = a - BusWires;
      OP_OR:   alu = a | BusWires;
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, (a < BusWires)};
      OP_SLL:  alu = a << BusWires[SW-1:0];
      OP_SRL:  alu = a >> BusWires[SW-1:0];
      default: alu = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
    end else begin
      step <= step_nxt;
      if (ir_ld) ir <= DIN[IW-1:0];
      if (a_ld)  a  <= BusWires;
      if (g_ld)  g  <= alu;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else if (r_wr) begin
      r[rx] <= BusWires;
    end
  end

endmodule
